// File: rtl/serial_tx_pkg.sv
// Shared types and line levels for the serial parity transmitter.
package serial_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic TX_IDLE_LVL  = 1'b1;
    localparam logic TX_START_LVL = 1'b0;
    localparam logic TX_STOP_LVL  = 1'b1;

endpackage

// File: rtl/serial_tx_baud.sv
// Bit-period divider: counts 0..DIV-1 while enabled and ticks on the last count.
module serial_tx_baud #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] div_cnt_q;
    logic [CW-1:0] div_cnt_d;

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (clr) begin
            div_cnt_d = '0;
        end else if (div_cnt_q == CW'(DIV - 1)) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign tick = !clr && (div_cnt_q == CW'(DIV - 1));

endmodule

// File: rtl/serial_parity_tx.sv
// Parallel-to-serial transmitter: start, data LSB-first, optional even parity, stop.
// Define SERIAL_TX_PARITY_EN to include the parity bit in each frame.
module serial_parity_tx
    import serial_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid,
    output logic             ready,
    output logic             txd,
    output logic             busy
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    tx_state_t        state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_idx_q, bit_idx_d;
    logic             txd_q, txd_d;
    logic             tick;
`ifdef SERIAL_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    // The divider is held at zero in IDLE so every frame starts on a fresh bit period.
    serial_tx_baud #(
        .DIV (DIV)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q == IDLE),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
`ifdef SERIAL_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (valid) begin
                    shreg_d   = data_in;
                    bit_idx_d = '0;
`ifdef SERIAL_TX_PARITY_EN
                    par_d     = ^data_in;
`endif
                    state_d   = START;
                end
            end
            START: if (tick) state_d = DATA;
            DATA: begin
                if (tick) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_idx_q == BW'(WIDTH - 1)) begin
                        bit_idx_d = '0;
`ifdef SERIAL_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: if (tick) state_d = STOP;
`endif
            STOP: if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // txd is decoded from the next state so the line is a clean flop output.
    always_comb begin
        txd_d = TX_IDLE_LVL;
        case (state_d)
            START:  txd_d = TX_START_LVL;
            DATA:   txd_d = shreg_d[0];
`ifdef SERIAL_TX_PARITY_EN
            PARITY: txd_d = par_d;
`endif
            STOP:   txd_d = TX_STOP_LVL;
            default: txd_d = TX_IDLE_LVL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            txd_q     <= TX_IDLE_LVL;
`ifdef SERIAL_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            txd_q     <= txd_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q != IDLE);
    assign txd   = txd_q;

    ready_busy_excl: assert property (@(posedge clk) disable iff (!rst_n) ready != busy);

endmodule

// File: tb/tb_serial_parity_tx.sv
// Self-checking bench for serial_parity_tx: directed frames, randomized words, held-valid
// back-to-back frames, mid-frame reset and a WIDTH=1/DIV=1 instance.
module tb_serial_parity_tx;

    localparam int W = 8;
    localparam int D = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         valid = 1'b0;
    logic         ready, txd, busy;

    logic         data1 = 1'b0;
    logic         valid1 = 1'b0;
    logic         ready1, txd1, busy1;

    int           n_chk = 0;
    int           n_fail = 0;
    logic         exp_q[$];

    serial_parity_tx #(.WIDTH(W), .DIV(D)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_in (data_in),
        .valid   (valid),
        .ready   (ready),
        .txd     (txd),
        .busy    (busy)
    );

    serial_parity_tx #(.WIDTH(1), .DIV(1)) u_small (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_in (data1),
        .valid   (valid1),
        .ready   (ready1),
        .txd     (txd1),
        .busy    (busy1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: list of line levels, one entry per clock.
    task automatic push_frame(input logic [W-1:0] w);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < W; i++) bits.push_back(w[i]);
        if (PB == 1) bits.push_back(logic'($countones(w) % 2));
        bits.push_back(1'b1);
        foreach (bits[k]) repeat (D) exp_q.push_back(bits[k]);
    endtask

    // Caller has presented the word at a negedge with ready high; the next posedge accepts it.
    task automatic run_frame(input logic [W-1:0] w, input bit keep, output logic [W-1:0] nxt);
        push_frame(w);
        @(posedge clk);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            if (keep) data_in = W'($urandom);
            else valid = 1'b0;
            chk("txd", 32'(txd), 32'(exp_q.pop_front()));
            chk("busy_in_frame", 32'(busy), 32'd1);
            chk("ready_in_frame", 32'(ready), 32'd0);
        end
        @(negedge clk);
        if (keep) data_in = W'($urandom);
        chk("ready_after", 32'(ready), 32'd1);
        chk("busy_after", 32'(busy), 32'd0);
        chk("txd_idle", 32'(txd), 32'd1);
        nxt = data_in;
    endtask

    task automatic send(input logic [W-1:0] w);
        logic [W-1:0] unused_nxt;
        @(negedge clk);
        valid   = 1'b1;
        data_in = w;
        run_frame(w, 1'b0, unused_nxt);
    endtask

    initial begin
        logic [W-1:0] nxt;
        logic         small_exp[$];

        // Reset held, then released.
        repeat (3) @(negedge clk);
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_txd1", 32'(txd1), 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_txd", 32'(txd), 32'd1);
        chk("post_rst_ready", 32'(ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Directed words.
        send(8'hA5);
        send(8'h07);
        send(8'h80);
        send(8'h00);
        send(8'hFF);

        // Randomized words with random idle gaps.
        for (int n = 0; n < 8; n++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            send(W'($urandom));
        end

        // valid held high with changing data: one word per frame, next accept straight after.
        @(negedge clk);
        valid   = 1'b1;
        data_in = W'($urandom);
        nxt     = data_in;
        for (int n = 0; n < 3; n++) run_frame(nxt, 1'b1, nxt);
        run_frame(nxt, 1'b0, nxt);

        // Reset asserted mid-frame: txd must return high without waiting for a clock edge.
        @(negedge clk);
        valid   = 1'b1;
        data_in = 8'h00;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_abort_txd", 32'(txd), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_txd", 32'(txd), 32'd1);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_idle_txd", 32'(txd), 32'd1);
        send(8'h3C);

        // WIDTH=1, DIV=1 instance sending a single 1 bit.
        small_exp.push_back(1'b0);
        small_exp.push_back(1'b1);
        if (PB == 1) small_exp.push_back(1'b1);
        small_exp.push_back(1'b1);
        @(negedge clk);
        valid1 = 1'b1;
        data1  = 1'b1;
        @(posedge clk);
        while (small_exp.size() > 0) begin
            @(negedge clk);
            valid1 = 1'b0;
            chk("small_txd", 32'(txd1), 32'(small_exp.pop_front()));
            chk("small_busy", 32'(busy1), 32'd1);
        end
        @(negedge clk);
        chk("small_ready", 32'(ready1), 32'd1);
        chk("small_txd_idle", 32'(txd1), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
